// File: rtl/fft_128_sched_if.sv
// Control/address bundle between the 128-point radix-2 FFT scheduler and its datapath.
// The scheduler uses the master modport; the datapath or bench uses the slave modport.
interface fft_128_sched_if;
  logic       start_i;
  logic       ce_i;
  logic       busy_o;
  logic       load_we_o;
  logic [6:0] load_addr_o;
  logic [6:0] rd_addr_a_o;
  logic [6:0] rd_addr_b_o;
  logic       bf_ce_o;
  logic [5:0] tw_idx_o;
  logic       wr_en_o;
  logic [6:0] wr_addr_a_o;
  logic [6:0] wr_addr_b_o;
  logic [2:0] stage_o;
  logic [6:0] out_addr_o;
  logic       oe_o;
  logic       done_o;

  modport master (
    input  start_i, ce_i,
    output busy_o, load_we_o, load_addr_o, rd_addr_a_o, rd_addr_b_o, bf_ce_o, tw_idx_o,
           wr_en_o, wr_addr_a_o, wr_addr_b_o, stage_o, out_addr_o, oe_o, done_o
  );
  modport slave (
    output start_i, ce_i,
    input  busy_o, load_we_o, load_addr_o, rd_addr_a_o, rd_addr_b_o, bf_ce_o, tw_idx_o,
           wr_en_o, wr_addr_a_o, wr_addr_b_o, stage_o, out_addr_o, oe_o, done_o
  );
endinterface

// File: rtl/fft_128_sched.sv
// In-place 128-point radix-2 FFT address/control scheduler: load, 7 butterfly stages, unload.
// Define FFT_BITREV_EN to bit-reverse load addresses (natural-order input stream).
module fft_128_sched #(
  parameter int BF_LAT     = 2,
  parameter int RAM_RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fft_128_sched_if.master bus
);
  localparam int         STAGES      = RAM_RD_LAT + BF_LAT;
  localparam logic [7:0] DRAIN_LAST  = 8'(STAGES);
  localparam logic [7:0] UNLOAD_LAST = 8'(127 + RAM_RD_LAT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STAGE, S_DRAIN, S_UNLOAD} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] stage_q, stage_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
    end
  end

  // One shared counter: sample index n, issue index j, drain wait, unload address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    unique case (state_q)
      S_IDLE: if (bus.start_i) begin
        state_d = S_LOAD;
        cnt_d   = '0;
        stage_d = '0;
      end
      S_LOAD: if (bus.ce_i) begin
        if (cnt_q == 8'd127) begin
          state_d = S_STAGE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_STAGE: begin
        if (cnt_q == 8'd63) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d = '0;
          if (stage_q == 3'd6) state_d = S_UNLOAD;
          else begin
            state_d = S_STAGE;
            stage_d = stage_q + 3'd1;
          end
        end else cnt_d = cnt_q + 8'd1;
      end
      S_UNLOAD: begin
        if (cnt_q == UNLOAD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          stage_d = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        stage_d = '0;
      end
    endcase
  end

  logic       issue_vld, unl_vld, unl_last;
  logic [6:0] j_ext, j_lo, mask, iss_a, iss_b, n_addr;
  logic [5:0] iss_tw;

  // Operand a is j with a zero bit inserted at position s; b is its partner at +2^s.
  always_comb begin
    issue_vld = (state_q == S_STAGE);
    mask      = (7'd1 << stage_q) - 7'd1;
    j_ext     = {1'b0, cnt_q[5:0]};
    j_lo      = j_ext & mask;
    iss_a     = '0;
    iss_b     = '0;
    iss_tw    = '0;
    if (issue_vld) begin
      iss_a  = ((j_ext >> stage_q) << (stage_q + 3'd1)) + j_lo;
      iss_b  = iss_a + (7'd1 << stage_q);
      iss_tw = j_lo[5:0] << (3'd6 - stage_q);
    end
    unl_vld  = (state_q == S_UNLOAD) && !cnt_q[7];
    unl_last = unl_vld && (cnt_q[6:0] == 7'd127);
  end

`ifdef FFT_BITREV_EN
  always_comb begin
    n_addr = '0;
    for (int i = 0; i < 7; i++) n_addr[i] = cnt_q[6-i];
  end
`else
  assign n_addr = cnt_q[6:0];
`endif

  // Delay lines: index 0 is the issue cycle, RAM_RD_LAT is bf_ce, STAGES is write-back.
  logic [STAGES:1]           vld_pipe_q;
  logic [STAGES:0]           vld_pipe;
  logic [STAGES:1][6:0]      a_pipe_q, b_pipe_q;
  logic [STAGES:0][6:0]      a_pipe, b_pipe;
  logic [RAM_RD_LAT:1][5:0]  tw_pipe_q;
  logic [RAM_RD_LAT:0][5:0]  tw_pipe;
  logic [RAM_RD_LAT:1]       oe_pipe_q, last_pipe_q;
  logic [RAM_RD_LAT:0]       oe_pipe, last_pipe;

  assign vld_pipe  = {vld_pipe_q, issue_vld};
  assign a_pipe    = {a_pipe_q, iss_a};
  assign b_pipe    = {b_pipe_q, iss_b};
  assign tw_pipe   = {tw_pipe_q, iss_tw};
  assign oe_pipe   = {oe_pipe_q, unl_vld};
  assign last_pipe = {last_pipe_q, unl_last};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      a_pipe_q    <= '0;
      b_pipe_q    <= '0;
      tw_pipe_q   <= '0;
      oe_pipe_q   <= '0;
      last_pipe_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe[STAGES-1:0];
      a_pipe_q    <= a_pipe[STAGES-1:0];
      b_pipe_q    <= b_pipe[STAGES-1:0];
      tw_pipe_q   <= tw_pipe[RAM_RD_LAT-1:0];
      oe_pipe_q   <= oe_pipe[RAM_RD_LAT-1:0];
      last_pipe_q <= last_pipe[RAM_RD_LAT-1:0];
    end
  end

  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.load_we_o   = (state_q == S_LOAD) && bus.ce_i;
  assign bus.load_addr_o = (state_q == S_LOAD) ? n_addr : '0;
  assign bus.rd_addr_a_o = iss_a;
  assign bus.rd_addr_b_o = iss_b;
  assign bus.bf_ce_o     = vld_pipe[RAM_RD_LAT];
  assign bus.tw_idx_o    = tw_pipe[RAM_RD_LAT];
  assign bus.wr_en_o     = vld_pipe[STAGES];
  assign bus.wr_addr_a_o = a_pipe[STAGES];
  assign bus.wr_addr_b_o = b_pipe[STAGES];
  assign bus.stage_o     = stage_q;
  // Address holds at 127 while the final read completes.
  assign bus.out_addr_o  = (state_q != S_UNLOAD) ? 7'd0 : (cnt_q[7] ? 7'd127 : cnt_q[6:0]);
  assign bus.oe_o        = oe_pipe[RAM_RD_LAT];
  assign bus.done_o      = last_pipe[RAM_RD_LAT];
endmodule

// File: tb/tb_fft_128_sched.sv
// Directed bench for fft_128_sched: load with a ce gap, full stage schedule, unload,
// mid-stage async reset, and a continuous-ce latency run.
module tb_fft_128_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  fft_128_sched_if bus();
  fft_128_sched #(.BF_LAT(2), .RAM_RD_LAT(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_la(input int n);
`ifdef FFT_BITREV_EN
    int r = 0;
    for (int i = 0; i < 7; i++) r = r | (((n >> i) & 1) << (6 - i));
    return r;
`else
    return n;
`endif
  endfunction

  // j-th address (ascending) whose bit s is clear: the lower operand of butterfly j.
  function automatic int nth_clear(input int s, input int j);
    int k = 0;
    for (int a = 0; a < 128; a++) begin
      if (((a >> s) & 1) == 0) begin
        if (k == j) return a;
        k++;
      end
    end
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    bus.busy_o,      0);
    chk({tag, "_load_we"}, bus.load_we_o,   0);
    chk({tag, "_load_ad"}, bus.load_addr_o, 0);
    chk({tag, "_rd_a"},    bus.rd_addr_a_o, 0);
    chk({tag, "_rd_b"},    bus.rd_addr_b_o, 0);
    chk({tag, "_bf_ce"},   bus.bf_ce_o,     0);
    chk({tag, "_tw"},      bus.tw_idx_o,    0);
    chk({tag, "_wr_en"},   bus.wr_en_o,     0);
    chk({tag, "_wr_a"},    bus.wr_addr_a_o, 0);
    chk({tag, "_wr_b"},    bus.wr_addr_b_o, 0);
    chk({tag, "_stage"},   bus.stage_o,     0);
    chk({tag, "_out_ad"},  bus.out_addr_o,  0);
    chk({tag, "_oe"},      bus.oe_o,        0);
    chk({tag, "_done"},    bus.done_o,      0);
  endtask

  initial begin
    int  n, lcyc, we_cnt, t0, s, r, h, last_wr, done_cnt, k;
    int  ea[480], eb[480], etw[480];
    bit  ev[480];
    logic ce;

    bus.start_i = 1'b0;
    bus.ce_i    = 1'b0;
    #1;
    chk_all_zero("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", bus.busy_o, 0);

    // ce while idle must be ignored
    bus.ce_i = 1'b1;
    #1;
    chk("idle_ce_we", bus.load_we_o, 0);
    @(negedge clk);
    chk("idle_ce_busy", bus.busy_o, 0);
    bus.ce_i = 1'b0;

    // ---- Run A: load with a ce gap at the 4th cycle ----
    t0 = cyc;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("a_busy", bus.busy_o, 1);
    n = 0; lcyc = 0; we_cnt = 0;
    while (n < 128 && lcyc < 200) begin
      ce = (lcyc == 3) ? 1'b0 : 1'b1;
      bus.ce_i = ce;
      #1;
      chk("load_we", bus.load_we_o, ce);
      chk("load_addr", bus.load_addr_o, exp_la(n));
      if (bus.load_we_o) we_cnt++;
      @(negedge clk);
      if (ce) n++;
      lcyc++;
    end
    chk("load_cycles", lcyc, 129);
    chk("load_we_cnt", we_cnt, 128);

    // ---- Stage schedule; ce held high to show it is ignored ----
    bus.ce_i = 1'b1;
    ev[0] = 0; ev[1] = 0; ev[2] = 0;
    last_wr = -10;
    for (int t = 0; t < 476; t++) begin
      s = t / 68; r = t % 68; h = 1 << s;
      ev[t+3] = (r < 64);
      if (ev[t+3]) begin
        ea[t+3]  = nth_clear(s, r);
        eb[t+3]  = ea[t+3] + h;
        etw[t+3] = (ea[t+3] % h) * (64 / h);
      end else begin
        ea[t+3] = 0; eb[t+3] = 0; etw[t+3] = 0;
      end
      chk("stage", bus.stage_o, s);
      chk("rd_a", bus.rd_addr_a_o, ea[t+3]);
      chk("rd_b", bus.rd_addr_b_o, eb[t+3]);
      chk("bf_ce", bus.bf_ce_o, ev[t+2]);
      if (ev[t+2]) chk("tw", bus.tw_idx_o, etw[t+2]);
      chk("wr_en", bus.wr_en_o, ev[t]);
      if (ev[t]) begin
        chk("wr_a", bus.wr_addr_a_o, ea[t]);
        chk("wr_b", bus.wr_addr_b_o, eb[t]);
      end
      chk("stage_ce_we", bus.load_we_o, 0);
      if (bus.wr_en_o) last_wr = t;
      if (r == 0 && s > 0) chk("rd_after_wr", t > last_wr, 1);
      if (s == 0 && r == 5) begin
        chk("s0j5_a", bus.rd_addr_a_o, 10);
        chk("s0j5_b", bus.rd_addr_b_o, 11);
      end
      if (s == 0 && r == 6) chk("s0j5_tw", bus.tw_idx_o, 0);
      if (s == 6 && r == 5) begin
        chk("s6j5_a", bus.rd_addr_a_o, 5);
        chk("s6j5_b", bus.rd_addr_b_o, 69);
      end
      if (s == 6 && r == 6) chk("s6j5_tw", bus.tw_idx_o, 5);
      @(negedge clk);
    end
    bus.ce_i = 1'b0;

    // ---- Unload, with a start pulse that must be ignored ----
    done_cnt = 0;
    for (int u = 0; u < 129; u++) begin
      if (u < 128) chk("out_addr", bus.out_addr_o, u);
      chk("oe", bus.oe_o, u >= 1);
      chk("done", bus.done_o, u == 128);
      chk("unl_busy", bus.busy_o, 1);
      if (bus.done_o) begin
        done_cnt++;
        chk("lat_gap", cyc - t0 + 1, 735);
      end
      bus.start_i = (u == 50);
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    chk("post_busy", bus.busy_o, 0);
    for (int i = 0; i < 5; i++) begin
      if (bus.done_o) done_cnt++;
      chk("post_idle", bus.busy_o, 0);
      @(negedge clk);
    end
    chk("done_pulses", done_cnt, 1);

    // ---- Run B: async reset in the middle of stage 3 ----
    bus.start_i = 1'b1;
    bus.ce_i    = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (128) @(negedge clk);
    repeat (224) @(negedge clk);
    chk("pre_rst_stage", bus.stage_o, 3);
    chk("pre_rst_wr", bus.wr_en_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.ce_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rel_busy", bus.busy_o, 0);
      chk("rel_wr_en", bus.wr_en_o, 0);
    end

    // ---- Run C: continuous ce; latency counted inclusively from the start cycle ----
    t0 = cyc;
    bus.start_i = 1'b1;
    bus.ce_i    = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    k = 0;
    while (!bus.done_o && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("c_done_seen", bus.done_o, 1);
    chk("c_latency", cyc - t0 + 1, 734);
    @(negedge clk);
    chk("c_busy_fall", bus.busy_o, 0);
    chk("c_done_low", bus.done_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
